// File: rtl/switch_nport_fifo_if.sv
// Bundle of the switch's input stream, per-port output streams and status.
// The master drives the input stream and output readies; the switch is the slave.
interface switch_nport_fifo_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                            in_vld;
    logic                            in_rdy;
    logic [ADDR_WIDTH-1:0]           in_addr;
    logic [DATA_WIDTH-1:0]           in_data;
    logic [NUM_PORTS-1:0]            out_vld;
    logic [NUM_PORTS-1:0]            out_rdy;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] out_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] out_data;
    logic [NUM_PORTS*LVL_W-1:0]      fill_lvl;
    logic [15:0]                     drop_cnt;

    modport master (
        output in_vld, in_addr, in_data, out_rdy,
        input  in_rdy, out_vld, out_addr, out_data, fill_lvl, drop_cnt
    );

    modport slave (
        input  in_vld, in_addr, in_data, out_rdy,
        output in_rdy, out_vld, out_addr, out_data, fill_lvl, drop_cnt
    );
endinterface

// File: rtl/switch_nport_fifo.sv
// N-port address-routed switch with a FIFO per output port.
// Stalled ports only block traffic headed to themselves; optional drop mode.
module switch_nport_fifo #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_PORTS    = 4,
    parameter int REGION_SIZE  = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int DROP_ON_FULL = 0
) (
    input logic              clk,
    input logic              rst,
    switch_nport_fifo_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int ENT_W  = ADDR_WIDTH + DATA_WIDTH;
    localparam int DEST_W = $clog2(NUM_PORTS);

    typedef logic [ENT_W-1:0] ent_t;

    ent_t             mem_q [NUM_PORTS][FIFO_DEPTH];
    ent_t             mem_d [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0] wr_ptr_d [NUM_PORTS];
    logic [PTR_W-1:0] rd_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0] rd_ptr_d [NUM_PORTS];
    logic [LVL_W-1:0] lvl_q [NUM_PORTS];
    logic [LVL_W-1:0] lvl_d [NUM_PORTS];
    logic [15:0]      drop_cnt_q;
    logic [15:0]      drop_cnt_d;

    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [31:0]          region;
    logic [DEST_W-1:0]    dest;
    logic                 dest_full;
    logic                 rdy;
    logic                 accept;
    logic                 drop;
    ent_t                 head;

    // Region index saturates so the top port owns everything above it
    always_comb begin
        region = 32'(bus.in_addr) / 32'(REGION_SIZE);
        if (region >= 32'(NUM_PORTS - 1))
            dest = DEST_W'(NUM_PORTS - 1);
        else
            dest = region[DEST_W-1:0];
    end

    always_comb begin
        full  = '0;
        empty = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            full[p]  = (lvl_q[p] == LVL_W'(FIFO_DEPTH));
            empty[p] = (lvl_q[p] == '0);
        end
    end

    // Ready looks only at the current level, never at a same-cycle pop
    always_comb begin
        dest_full = full[dest];
        if (rst)
            rdy = 1'b0;
        else if (DROP_ON_FULL != 0)
            rdy = 1'b1;
        else
            rdy = !dest_full;
        accept = bus.in_vld && rdy && !dest_full;
        drop   = (DROP_ON_FULL != 0) && rdy && bus.in_vld && dest_full;
    end

    assign bus.in_rdy = rdy;

    always_comb begin
        push     = '0;
        pop      = '0;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        lvl_d    = lvl_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            push[p]     = accept && (dest == DEST_W'(p));
            pop[p]      = !empty[p] && bus.out_rdy[p];
            wr_ptr_d[p] = wr_ptr_q[p] + PTR_W'(push[p]);
            rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(pop[p]);
            lvl_d[p]    = lvl_q[p] + LVL_W'(push[p]) - LVL_W'(pop[p]);
            if (push[p])
                mem_d[p][wr_ptr_q[p]] = {bus.in_addr, bus.in_data};
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_comb begin
        head         = '0;
        bus.out_vld  = ~empty;
        bus.out_addr = '0;
        bus.out_data = '0;
        bus.fill_lvl = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            head = empty[p] ? '0 : mem_q[p][rd_ptr_q[p]];
            bus.out_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = head[ENT_W-1 -: ADDR_WIDTH];
            bus.out_data[p*DATA_WIDTH +: DATA_WIDTH] = head[DATA_WIDTH-1:0];
            bus.fill_lvl[p*LVL_W +: LVL_W]           = lvl_q[p];
        end
    end

    assign bus.drop_cnt = drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                lvl_q[p]    <= '0;
            end
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lvl_q      <= lvl_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: empty FIFOs mask their head to zero
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule
